// File: rtl/ysyx_24090010_lsu.sv
// Multi-cycle load/store unit: execute-side request/response to a word-wide request/grant memory bus.
// Optional build macro MISALIGN_TRAP_EN turns misaligned halfword/word accesses into error responses.
module ysyx_24090010_lsu #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_funct3,
    input  logic        in_wen,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_e;

    function automatic logic f3_legal(input logic [2:0] f3, input logic wn);
        logic ok;
        case (f3)
            3'd0, 3'd1, 3'd2: ok = 1'b1;
            3'd4, 3'd5:       ok = !wn;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords are forced to an even offset and words to offset 0 when misalignment is not trapped.
    function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] a);
        logic [1:0] o;
        case (f3[1:0])
            2'b00:   o = a;
            2'b01:   o = {a[1], 1'b0};
            default: o = 2'b00;
        endcase
        return o;
    endfunction

    function automatic logic [3:0] st_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s;
        case (f3[1:0])
            2'b00:   s = 4'b0001 << off;
            2'b01:   s = 4'b0011 << off;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] st_rep(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{w[7:0]}};
            2'b01:   r = {2{w[15:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rd >> {off, 3'b000};
        case (f3)
            3'd0:    r = {{24{sh[7]}}, sh[7:0]};
            3'd1:    r = {{16{sh[15]}}, sh[15:0]};
            3'd4:    r = {24'd0, sh[7:0]};
            3'd5:    r = {16'd0, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    state_e        state_q, state_d;
    logic [31:2]   addr_q, addr_d;
    logic [2:0]    f3_q, f3_d;
    logic          wen_q, wen_d;
    logic [1:0]    off_q, off_d;
    logic [3:0]    strb_q, strb_d;
    logic [31:0]   wrep_q, wrep_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q;
    logic          misal_s;

`ifdef MISALIGN_TRAP_EN
    assign misal_s = (in_funct3[1:0] == 2'b01) ? in_addr[0] :
                     (in_funct3[1:0] == 2'b10) ? (in_addr[1:0] != 2'b00) : 1'b0;
`else
    assign misal_s = 1'b0;
`endif

    // Next-state and datapath-capture logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wen_d   = wen_q;
        off_d   = off_q;
        strb_d  = strb_q;
        wrep_d  = wrep_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    addr_d  = in_addr[31:2];
                    f3_d    = in_funct3;
                    wen_d   = in_wen;
                    off_d   = eff_off(in_funct3, in_addr[1:0]);
                    strb_d  = in_wen ? st_strb(in_funct3, eff_off(in_funct3, in_addr[1:0])) : 4'b0000;
                    wrep_d  = in_wen ? st_rep(in_funct3, in_wdata) : 32'd0;
                    rdata_d = 32'd0;
                    cnt_d   = {CW{1'b0}};
                    if (!f3_legal(in_funct3, in_wen) || misal_s) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = wen_q ? 32'd0 : ld_ext(f3_q, off_q, mem_rdata);
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched-request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= 30'd0;
            f3_q       <= 3'd0;
            wen_q      <= 1'b0;
            off_q      <= 2'd0;
            strb_q     <= 4'd0;
            wrep_q     <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            cnt_q      <= {CW{1'b0}};
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            f3_q       <= f3_d;
            wen_q      <= wen_d;
            off_q      <= off_d;
            strb_q     <= strb_d;
            wrep_q     <= wrep_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            in_ready_q <= (state_d == S_IDLE);
        end
    end

    // Bus and response outputs are held at zero outside the state that owns them.
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == S_RESP);
    assign out_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
    assign out_err   = (state_q == S_RESP) ? err_q : 1'b0;
    assign mem_req   = (state_q == S_REQ);
    assign mem_addr  = (state_q == S_REQ) ? {addr_q, 2'b00} : 32'd0;
    assign mem_wen   = (state_q == S_REQ) ? wen_q : 1'b0;
    assign mem_wstrb = (state_q == S_REQ) ? strb_q : 4'd0;
    assign mem_wdata = (state_q == S_REQ) ? wrep_q : 32'd0;
endmodule

// File: tb/tb_ysyx_24090010_lsu.sv
// Directed bench for ysyx_24090010_lsu: a scoreboard queue holds expected responses pushed at issue time.
module tb_ysyx_24090010_lsu;
    localparam int TO = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = 32'd0;
    logic [31:0] in_wdata = 32'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic        in_wen = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ysyx_24090010_lsu #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_funct3(in_funct3), .in_wen(in_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic [2:0] f3,
                         input logic wn, input logic [31:0] er, input logic ee);
        exp_t e;
        chk("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; in_addr = a; in_wdata = w; in_funct3 = f3; in_wen = wn;
        e.rdata = er; e.err = ee;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0; in_addr = 32'd0; in_wdata = 32'd0; in_funct3 = 3'd0; in_wen = 1'b0;
        chk("in_ready_busy", in_ready, 1'b0);
    endtask

    // rd < 0 means the bus never answers.
    task automatic bus(input int gd, input int rd, input logic [31:0] rw, input logic [31:0] ea,
                       input logic ewn, input logic [3:0] es, input logic [31:0] ew);
        for (int i = 0; i < gd; i++) begin
            chk("req_hold", mem_req, 1'b1);
            chk("addr_hold", mem_addr, ea);
            chk("in_ready_req", in_ready, 1'b0);
            @(negedge clk);
        end
        chk("mem_req", mem_req, 1'b1);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wen", mem_wen, ewn);
        chk("mem_wstrb", mem_wstrb, es);
        if (ewn) chk("mem_wdata", mem_wdata, ew);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("req_drop_wait", mem_req, 1'b0);
        chk("no_valid_wait", out_valid, 1'b0);
        if (rd >= 0) begin
            for (int j = 0; j < rd; j++) @(negedge clk);
            mem_rvalid = 1'b1; mem_rdata = rw;
            @(negedge clk);
            mem_rvalid = 1'b0; mem_rdata = 32'd0;
        end
    endtask

    task automatic resp(input int exp_n, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("resp_latency", n, exp_n);
        chk("out_valid", out_valid, 1'b1);
        chk("sb_nonempty", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        else begin e.rdata = 32'd0; e.err = 1'b0; end
        chk("out_rdata", out_rdata, e.rdata);
        chk("out_err", out_err, e.err);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("valid_hold", out_valid, 1'b1);
            chk("rdata_hold", out_rdata, e.rdata);
            chk("err_hold", out_err, e.err);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 1'b0);
        chk("in_ready_back", in_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);

        // LW, fastest bus: 3 cycles accept to out_valid
        issue(32'h8000_0004, 32'd0, 3'd2, 1'b0, 32'hDEAD_BEEF, 1'b0);
        bus(0, 0, 32'hDEAD_BEEF, 32'h8000_0004, 1'b0, 4'b0000, 32'd0);
        resp(0, 0);

        // LB / LBU top byte
        issue(32'h8000_0003, 32'd0, 3'd0, 1'b0, 32'hFFFF_FF80, 1'b0);
        bus(0, 0, 32'h80FF_1234, 32'h8000_0000, 1'b0, 4'b0000, 32'd0);
        resp(0, 0);
        issue(32'h8000_0003, 32'd0, 3'd4, 1'b0, 32'h0000_0080, 1'b0);
        bus(0, 1, 32'h80FF_1234, 32'h8000_0000, 1'b0, 4'b0000, 32'd0);
        resp(0, 0);

        // LH / LHU upper half
        issue(32'h8000_0002, 32'd0, 3'd1, 1'b0, 32'hFFFF_F00D, 1'b0);
        bus(0, 0, 32'hF00D_1234, 32'h8000_0000, 1'b0, 4'b0000, 32'd0);
        resp(0, 0);
        issue(32'h8000_0006, 32'd0, 3'd5, 1'b0, 32'h0000_7FFF, 1'b0);
        bus(0, 0, 32'h7FFF_8001, 32'h8000_0004, 1'b0, 4'b0000, 32'd0);
        resp(0, 0);

        // SH and SB strobes/replication
        issue(32'h8000_0002, 32'h0000_ABCD, 3'd1, 1'b1, 32'd0, 1'b0);
        bus(0, 0, 32'h1234_5678, 32'h8000_0000, 1'b1, 4'b1100, 32'hABCD_ABCD);
        resp(0, 0);
        issue(32'h8000_0001, 32'h1234_56A5, 3'd0, 1'b1, 32'd0, 1'b0);
        bus(0, 0, 32'd0, 32'h8000_0000, 1'b1, 4'b0010, 32'hA5A5_A5A5);
        resp(0, 0);

        // SW with grant stalled 5 cycles and consumer stalled 3 cycles
        issue(32'h8000_0008, 32'h1234_5678, 3'd2, 1'b1, 32'd0, 1'b0);
        bus(5, 2, 32'd0, 32'h8000_0008, 1'b1, 4'b1111, 32'h1234_5678);
        resp(0, 3);

        // Timeout after TO wait cycles, then a late rvalid in IDLE is ignored
        issue(32'h8000_000C, 32'd0, 3'd2, 1'b0, 32'd0, 1'b1);
        bus(0, -1, 32'd0, 32'h8000_000C, 1'b0, 4'b0000, 32'd0);
        resp(TO, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        chk("late_rvalid_valid", out_valid, 1'b0);
        chk("late_rvalid_ready", in_ready, 1'b1);
        chk("late_rvalid_req", mem_req, 1'b0);
        issue(32'h8000_0010, 32'd0, 3'd2, 1'b0, 32'hCAFE_F00D, 1'b0);
        bus(0, 0, 32'hCAFE_F00D, 32'h8000_0010, 1'b0, 4'b0000, 32'd0);
        resp(0, 0);

        // Misaligned LW
`ifdef MISALIGN_TRAP_EN
        issue(32'h8000_0001, 32'd0, 3'd2, 1'b0, 32'd0, 1'b1);
        chk("misal_no_req", mem_req, 1'b0);
        resp(0, 0);
`else
        issue(32'h8000_0001, 32'd0, 3'd2, 1'b0, 32'h1122_3344, 1'b0);
        bus(0, 0, 32'h1122_3344, 32'h8000_0000, 1'b0, 4'b0000, 32'd0);
        resp(0, 0);
`endif

        // Illegal funct3 for load and store
        issue(32'h8000_0000, 32'd0, 3'd3, 1'b0, 32'd0, 1'b1);
        chk("illegal_no_req", mem_req, 1'b0);
        resp(0, 0);
        issue(32'h8000_0000, 32'h0000_00FF, 3'd4, 1'b1, 32'd0, 1'b1);
        chk("illegal_st_no_req", mem_req, 1'b0);
        resp(0, 0);

        // Reset while waiting for the bus aborts the access and drops the response
        issue(32'h8000_0020, 32'd0, 3'd2, 1'b0, 32'd0, 1'b0);
        bus(0, -1, 32'd0, 32'h8000_0020, 1'b0, 4'b0000, 32'd0);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        void'(sb_q.pop_front());
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_out_rdata", out_rdata, 32'd0);
        chk("abort_mem_req", mem_req, 1'b0);
        chk("abort_in_ready", in_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_release_ready", in_ready, 1'b1);
        chk("abort_release_valid", out_valid, 1'b0);
        issue(32'h8000_0024, 32'd0, 3'd2, 1'b0, 32'h0BAD_CAFE, 1'b0);
        bus(0, 0, 32'h0BAD_CAFE, 32'h8000_0024, 1'b0, 4'b0000, 32'd0);
        resp(0, 0);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_24090010_lsu.md
Name: ysyx_24090010_lsu

Overview:
Multi-cycle load/store unit between the execute datapath (address, store data, funct3 from ALU/IDU) and a word-wide memory bus with request/grant and response handshakes. Replaces the single-cycle RAM access. Generates byte strobes and replicates store data. Extracts, shifts and sign/zero-extends load data. Reports illegal-size, misaligned and timed-out accesses as an error on the response.

Parameters:
TIMEOUT_CYC, 256, cycles in WAIT without mem_rvalid before the access is aborted with error (must be >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
in_valid  input  1  access request from execute
in_ready  output  1  LSU can accept a request
in_addr  input  32  byte address
in_wdata  input  32  store data, value in low bits
in_funct3  input  3  RISC-V load/store funct3
in_wen  input  1  1 = store, 0 = load
out_valid  output  1  response valid
out_ready  input  1  consumer accepts response
out_rdata  output  32  extended load data; 0 for stores/errors
out_err  output  1  access failed
mem_req  output  1  bus request
mem_gnt  input  1  bus grant
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_wen  output  1  write
mem_wstrb  output  4  byte strobes; 0 for reads
mem_wdata  output  32  replicated store data
mem_rvalid  input  1  bus response (reads and writes)
mem_rdata  input  32  read word

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset (rst=0 at edge): state IDLE; all outputs 0 except in_ready=1 after reset release; timeout counter 0; latched request cleared. Reset mid-operation aborts the access. A pending bus response is dropped.
- IDLE: in_ready=1. On in_valid, latch addr, wdata, funct3 and wen. If the request is illegal or misaligned (see below), go to RESP with err=1 and make no bus access. Otherwise go to REQ.
- REQ: mem_req=1 with mem_addr/mem_wen/mem_wstrb/mem_wdata stable until mem_gnt. On mem_gnt, go to WAIT and clear the counter.
- WAIT: mem_req=0. On mem_rvalid, capture the result and go to RESP with err=0. Otherwise the counter increments. When the counter reaches TIMEOUT_CYC-1 with no rvalid, go to RESP with err=1 and rdata=0.
- mem_rvalid outside WAIT is ignored, including a late response after a timeout.
- RESP: out_valid=1, out_rdata/out_err stable until out_ready. Then go to IDLE. in_ready=0 in REQ, WAIT and RESP.
- Minimum latency is 3 cycles from accept to out_valid (gnt in the first REQ cycle, rvalid in the first WAIT cycle). An illegal or misaligned request gives out_valid in the cycle after accept.
- Legal funct3 values:
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
  - Any other value is illegal and sets err=1.
- Strobes:
  - SB: 4'b0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
  - SH: 4'b0011<<{addr[1],1'b0}, mem_wdata={2{wdata[15:0]}}.
  - SW: 4'b1111, mem_wdata=wdata.
- Loads: shift mem_rdata right by addr[1:0]*8. Then:
  - LB/LBU: sign/zero-extend bits [7:0].
  - LH/LHU: sign/zero-extend bits [15:0].
  - LW: the whole word.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned. It gives err=1 and out_rdata=0, with no bus access.
- Undefined: no misalignment check. Halfword accesses use byte offset {addr[1],1'b0} and word accesses use offset 0. err comes only from illegal funct3 or timeout.

Test Plan:
- LW at 0x80000004, gnt immediate, rvalid next cycle with 0xDEADBEEF -> mem_addr=0x80000004, wstrb=0, out_valid 3 cycles after accept, rdata=0xDEADBEEF, err=0.
- LB at 0x80000003, mem_rdata=0x80FF1234 -> rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x80000002, wdata=0x0000ABCD -> wstrb=4'b1100, mem_wdata=0xABCDABCD, mem_wen=1. Response rdata=0.
- gnt held low 5 cycles -> mem_req and address stable all 5 cycles, in_ready=0. out_ready held low 3 cycles -> out_valid and rdata stable.
- With TIMEOUT_CYC=4, no rvalid -> out_err=1 after 4 WAIT cycles. A late rvalid in IDLE is ignored and the next LW completes normally.
- LW at 0x80000001: with MISALIGN_TRAP_EN -> err=1 next cycle, mem_req never asserted; without it -> mem_addr=0x80000000, full word returned. funct3=3 -> err=1 in both builds. rst=0 during WAIT -> IDLE, outputs 0 at the next edge.
